// File: rtl/yuv420_frame_ctrl_pkg.sv
// Shared types and constants for the yuv420 frame sequencer: stream dtype codes,
// FSM state encoding (also used for host state readback) and the latched frame config.
package yuv420_frame_ctrl_pkg;

  localparam int unsigned DTYPE_W    = 4;
  localparam int unsigned IMG_TYPE_W = 16;

  localparam logic [DTYPE_W-1:0] DTYPE_FRAME_START = 4'h1;
  localparam logic [DTYPE_W-1:0] DTYPE_FRAME_END   = 4'h2;
  localparam logic [DTYPE_W-1:0] DTYPE_PIXEL_MASK  = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SKIP    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  typedef struct packed {
    logic [IMG_TYPE_W-1:0] image_type;
    logic                  enable;
  } frame_cfg_t;

endpackage

// File: rtl/yuv420_frame_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module yuv420_frame_ctrl_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/yuv420_frame_ctrl.sv
// Frame-level sequencer ahead of the yuv420 packer: admits whole frames only when the
// downstream FIFO can hold them, latches per-frame config at FS, and keeps host counters.
module yuv420_frame_ctrl
  import yuv420_frame_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_CNT_WIDTH = 16,
  parameter int unsigned WORD_CNT_WIDTH  = 24
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       start,
  input  logic                       stop,
  input  logic [IMG_TYPE_W-1:0]      cfg_image_type,
  input  logic                       cfg_enable,
  input  logic [FRAME_CNT_WIDTH-1:0] cfg_num_frames,
  input  logic [WORD_CNT_WIDTH-1:0]  cfg_frame_words,
  input  logic [WORD_CNT_WIDTH-1:0]  fifo_free_words,
  input  logic                       dvi,
  input  logic [DTYPE_W-1:0]         dtypei,
  output logic                       dvo_gate,
  output logic [IMG_TYPE_W-1:0]      image_type,
  output logic                       yuv_enable,
  input  logic                       pk_dv,
  input  logic [DTYPE_W-1:0]         pk_dtype,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frames_captured,
  output logic [FRAME_CNT_WIDTH-1:0] frames_dropped,
  output logic [WORD_CNT_WIDTH-1:0]  frame_word_cnt
);

  logic fs_in, fe_in, pk_fs, pk_fe, pk_pix, fits;
  state_t                     state, state_nxt;
  logic                       pass, pass_nxt;
  logic                       stop_pend, stop_pend_nxt;
  logic [FRAME_CNT_WIDTH-1:0] frames_left, frames_left_nxt;
  frame_cfg_t                 cfg_q, cfg_nxt;
  logic                       gate_c, clr_cnt, inc_cap, inc_drop, latch_wc;
  logic [WORD_CNT_WIDTH-1:0]  word_cnt;

  assign fs_in  = dvi && (dtypei == DTYPE_FRAME_START);
  assign fe_in  = dvi && (dtypei == DTYPE_FRAME_END);
  assign pk_fs  = pk_dv && (pk_dtype == DTYPE_FRAME_START);
  assign pk_fe  = pk_dv && (pk_dtype == DTYPE_FRAME_END);
  assign pk_pix = pk_dv && (|(pk_dtype & DTYPE_PIXEL_MASK));
  assign fits   = fifo_free_words >= cfg_frame_words;

  assign dvo_gate   = dvi & gate_c;
  assign image_type = cfg_q.image_type;
  assign yuv_enable = cfg_q.enable;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state          <= ST_IDLE;
      pass           <= 1'b0;
      stop_pend      <= 1'b0;
      frames_left    <= '0;
      cfg_q          <= '0;
      busy           <= 1'b0;
      frame_word_cnt <= '0;
    end else begin
      state       <= state_nxt;
      pass        <= pass_nxt;
      stop_pend   <= stop_pend_nxt;
      frames_left <= frames_left_nxt;
      cfg_q       <= cfg_nxt;
      busy        <= (state_nxt != ST_IDLE);
      if (clr_cnt) begin
        frame_word_cnt <= '0;
      end else if (latch_wc) begin
        frame_word_cnt <= word_cnt;
      end
    end
  end

  // Gate is opened combinationally on the admitted FS so the frame start is forwarded
  // the same cycle; a second FS while capturing is withheld and closes the frame.
  always_comb begin
    state_nxt       = state;
    pass_nxt        = pass;
    stop_pend_nxt   = stop_pend;
    frames_left_nxt = frames_left;
    cfg_nxt         = cfg_q;
    gate_c          = pass;
    clr_cnt         = 1'b0;
    inc_cap         = 1'b0;
    inc_drop        = 1'b0;
    latch_wc        = 1'b0;
    case (state)
      ST_IDLE: begin
        pass_nxt      = 1'b0;
        stop_pend_nxt = 1'b0;
        if (start) begin
          clr_cnt         = 1'b1;
          frames_left_nxt = cfg_num_frames;
          stop_pend_nxt   = stop;
          state_nxt       = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (stop) begin
          stop_pend_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end else if (fs_in) begin
          if (fits) begin
            cfg_nxt.image_type = cfg_image_type;
            cfg_nxt.enable     = cfg_enable;
            pass_nxt           = 1'b1;
            gate_c             = 1'b1;
            state_nxt          = ST_CAPTURE;
          end else begin
            inc_drop  = 1'b1;
            state_nxt = ST_SKIP;
          end
        end
      end
      ST_SKIP: begin
        pass_nxt = 1'b0;
        gate_c   = 1'b0;
        if (stop) begin
          stop_pend_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end else if (fe_in) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        gate_c = pass & ~fs_in;
        if (stop) begin
          stop_pend_nxt = 1'b1;
        end
        if (fs_in) begin
          inc_drop  = 1'b1;
          pass_nxt  = 1'b0;
          state_nxt = ST_DRAIN;
        end else if (fe_in) begin
          pass_nxt  = 1'b0;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pass_nxt = 1'b0;
        if (stop) begin
          stop_pend_nxt = 1'b1;
        end
        if (pk_fe) begin
          inc_cap  = 1'b1;
          latch_wc = 1'b1;
          if (stop_pend || stop ||
              ((cfg_num_frames != '0) && (frames_left == FRAME_CNT_WIDTH'(1)))) begin
            state_nxt = ST_IDLE;
          end else begin
            frames_left_nxt = frames_left - FRAME_CNT_WIDTH'(1);
            state_nxt       = ST_ARMED;
          end
        end
      end
      default: begin
        pass_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  yuv420_frame_ctrl_sat_counter #(.WIDTH(FRAME_CNT_WIDTH)) u_cap_cnt (
    .clk(clk), .resetb(resetb), .clr(clr_cnt), .inc(inc_cap), .q(frames_captured)
  );

  yuv420_frame_ctrl_sat_counter #(.WIDTH(FRAME_CNT_WIDTH)) u_drop_cnt (
    .clk(clk), .resetb(resetb), .clr(clr_cnt), .inc(inc_drop), .q(frames_dropped)
  );

  // Counts packer pixel words of the frame currently leaving the packer.
  yuv420_frame_ctrl_sat_counter #(.WIDTH(WORD_CNT_WIDTH)) u_word_cnt (
    .clk(clk), .resetb(resetb), .clr(clr_cnt | pk_fs), .inc(pk_pix), .q(word_cnt)
  );

endmodule
